np_write_arbiter: RTL

NP_WRITE_ARBITER -- requirements
Module: np_write_arbiter

---
 rtl/np_write_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/np_write_arbiter.sv
// Two-port round-robin pixel-write arbiter driving a neopixel driver through a
// SETUP/STROBE handshake. Define NP_FRAME_FILL_EN to compile in the whole-strip fill.
module np_write_arbiter #(
   parameter int NUM_LEDS      = 64,
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [15:0] req0_addr,
   input  logic [23:0] req0_color,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_addr,
   input  logic [23:0] req1_color,
   output logic        req1_ready,
   input  logic        fill_start,
   input  logic [23:0] fill_color,
   output logic        fill_done,
   output logic [23:0] np_color,
   output logic [15:0] np_address,
   output logic        np_color_clock,
   output logic        busy,
   output logic        err,
   input  logic        err_clr
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_e;

   localparam int CMAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
   localparam logic [16:0]   ADDR_LIMIT  = 17'(NUM_LEDS);
   localparam logic [15:0]   LAST_ADDR   = 16'(NUM_LEDS - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   color_q, color_d;
   logic [15:0]   addr_q, addr_d;
   logic          last_q, last_d;   // 1: req1 was granted last
   logic          err_q, err_d;
   logic          fill_q, fill_d;
   logic          done_q, done_d;
   logic          gnt0, gnt1, in_range, fill_go;
   logic [15:0]   sel_addr;
   logic [23:0]   sel_color, fill_rgb;

`ifdef NP_FRAME_FILL_EN
   assign fill_go   = fill_start;
   assign fill_rgb  = fill_color;
   assign fill_done = done_q;
`else
   assign fill_go   = 1'b0;
   assign fill_rgb  = '0;
   assign fill_done = 1'b0;
   logic unused_fill;
   assign unused_fill = ^{fill_start, fill_color, done_q};
`endif

   assign sel_addr  = gnt1 ? req1_addr : req0_addr;
   assign sel_color = gnt1 ? req1_color : req0_color;
   assign in_range  = {1'b0, sel_addr} < ADDR_LIMIT;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      color_d = color_q;
      addr_d  = addr_q;
      last_d  = last_q;
      err_d   = err_q;
      fill_d  = fill_q;
      done_d  = 1'b0;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      if (err_clr) err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (fill_go) begin
               state_d = SETUP;
               cnt_d   = '0;
               addr_d  = '0;
               color_d = fill_rgb;
               fill_d  = 1'b1;
            end else begin
               gnt0 = req0_valid && (!req1_valid || last_q);
               gnt1 = req1_valid && (!req0_valid || !last_q);
               if (gnt0 || gnt1) begin
                  last_d = gnt1;
                  // Out-of-range writes are still acknowledged so the requester never stalls.
                  if (in_range) begin
                     state_d = SETUP;
                     cnt_d   = '0;
                     addr_d  = sel_addr;
                     color_d = sel_color;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = STROBE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               cnt_d = '0;
               if (fill_q && addr_q != LAST_ADDR) begin
                  state_d = SETUP;
                  addr_d  = addr_q + 16'd1;
               end else begin
                  state_d = IDLE;
                  done_d  = fill_q;
                  fill_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         color_q <= '0;
         addr_q  <= '0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         fill_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         color_q <= color_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         err_q   <= err_d;
         fill_q  <= fill_d;
         done_q  <= done_d;
      end
   end

   // Ready is gated with rst_n since the state already reads IDLE during reset.
   assign req0_ready     = gnt0 & rst_n;
   assign req1_ready     = gnt1 & rst_n;
   assign np_color       = color_q;
   assign np_address     = addr_q;
   assign np_color_clock = (state_q == STROBE);
   assign busy           = (state_q != IDLE);
   assign err            = err_q;
endmodule
